ajuste_relogio: RTL

//  Upstream time-set controller for the digital clock. Debounces two board pushbuttons and runs a
//  RUN / SET_HOUR / SET_MIN mode FSM. Drives the hour/minute/second counter stages with:
//  a gated 1 Hz advance enable, single-cycle increment pulses and a seconds-clear pulse.

---
 rtl/relogio_pkg.sv | 24 ++
 rtl/ajuste_relogio_debounce_tecla.sv | 69 ++++++
 rtl/ajuste_relogio.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/relogio_pkg.sv
// Shared types and default timing constants for the clock time-set controller.
package relogio_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } ajuste_state_t;

    localparam int unsigned DEB_CYCLES_DEF = 1_000_000;
    localparam int unsigned TIMEOUT_S_DEF  = 30;
    localparam int unsigned REP_DELAY_DEF  = 25_000_000;
    localparam int unsigned REP_PERIOD_DEF = 10_000_000;

    // The mode key walks RUN -> SET_HOUR -> SET_MIN -> RUN.
    function automatic ajuste_state_t next_mode(input ajuste_state_t s);
        case (s)
            RUN:      return SET_HOUR;
            SET_HOUR: return SET_MIN;
            default:  return RUN;
        endcase
    endfunction

endpackage

// File: rtl/ajuste_relogio_debounce_tecla.sv
// debounce_tecla: 2-FF synchroniser, stability counter and one-cycle press pulse
// for one active-low pushbutton.
module debounce_tecla
    import relogio_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic press_o,
    output logic held_o
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

    logic          sync1_q, sync2_q;
    logic          level_q, level_prev_q;
    logic          armed_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;
    logic          cnt_done;

    assign cnt_done = (cnt_q == CW'(DEB_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            level_q      <= 1'b1;
            level_prev_q <= 1'b1;
            armed_q      <= 1'b0;
            cnt_q        <= '0;
            press_q      <= 1'b0;
        end else begin
            sync1_q      <= key_n_i;
            sync2_q      <= sync1_q;
            level_prev_q <= level_q;
            press_q      <= level_prev_q & ~level_q;
            // After reset the key must be seen released for a full debounce
            // window before any press can be accepted.
            if (!armed_q) begin
                if (sync2_q) begin
                    if (cnt_done) begin
                        armed_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end else begin
                    cnt_q <= '0;
                end
            end else if (sync2_q != level_q) begin
                if (cnt_done) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign press_o = press_q;
    assign held_o  = armed_q & ~level_q;

endmodule

// File: rtl/ajuste_relogio.sv
// ajuste_relogio: RUN / SET_HOUR / SET_MIN time-set controller with blink masks and timeout.
// Optional key_inc auto-repeat is built only when AJUSTE_AUTO_REPEAT_EN is defined.
module ajuste_relogio
    import relogio_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned TIMEOUT_S  = TIMEOUT_S_DEF,
    parameter int unsigned REP_DELAY  = REP_DELAY_DEF,
    parameter int unsigned REP_PERIOD = REP_PERIOD_DEF
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_mode_n,
    input  logic key_inc_n,
    input  logic tick_1hz,
    output logic run_tick,
    output logic inc_hour,
    output logic inc_minute,
    output logic clr_seconds,
    output logic blank_h,
    output logic blank_m,
    output logic set_active
);

    localparam int unsigned TW = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S + 1) : 1;

    ajuste_state_t state_q;
    logic          blink_q;
    logic [TW-1:0] tcnt_q;
    logic          inc_hour_q, inc_minute_q, clr_seconds_q;

    logic mode_press, mode_held, inc_press, inc_held;
    logic rep_fire, inc_event, in_set;
    logic unused_keys;

    debounce_tecla #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk_i   (CLOCK_50),
        .rst_i   (reset),
        .key_n_i (key_mode_n),
        .press_o (mode_press),
        .held_o  (mode_held)
    );

    debounce_tecla #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk_i   (CLOCK_50),
        .rst_i   (reset),
        .key_n_i (key_inc_n),
        .press_o (inc_press),
        .held_o  (inc_held)
    );

    assign in_set    = (state_q != RUN);
    assign inc_event = inc_press | rep_fire;

`ifdef AJUSTE_AUTO_REPEAT_EN
    localparam int unsigned REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int unsigned RW      = $clog2(REP_MAX + 1);

    logic          rep_active_q, rep_first_q;
    logic [RW-1:0] rep_cnt_q;
    logic          rep_hit;

    // rep_cnt_q counts cycles the key has been held since acceptance or the last repeat.
    assign rep_hit  = (rep_cnt_q == (rep_first_q ? RW'(REP_DELAY) : RW'(REP_PERIOD)));
    assign rep_fire = rep_active_q & rep_hit & inc_held & in_set & ~mode_press;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rep_active_q <= 1'b0;
            rep_first_q  <= 1'b1;
            rep_cnt_q    <= '0;
        end else if (!inc_held || !in_set || mode_press) begin
            rep_active_q <= 1'b0;
            rep_first_q  <= 1'b1;
            rep_cnt_q    <= '0;
        end else begin
            if (inc_press) begin
                rep_active_q <= 1'b1;
            end
            if (rep_fire) begin
                rep_first_q <= 1'b0;
                rep_cnt_q   <= RW'(1);
            end else if (rep_cnt_q != RW'(REP_MAX)) begin
                rep_cnt_q <= rep_cnt_q + RW'(1);
            end
        end
    end

    assign unused_keys = mode_held;
`else
    assign rep_fire    = 1'b0;
    assign unused_keys = mode_held ^ inc_held ^ (REP_DELAY != REP_PERIOD);
`endif

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            blink_q       <= 1'b0;
            tcnt_q        <= '0;
            inc_hour_q    <= 1'b0;
            inc_minute_q  <= 1'b0;
            clr_seconds_q <= 1'b0;
        end else begin
            inc_hour_q    <= 1'b0;
            inc_minute_q  <= 1'b0;
            clr_seconds_q <= 1'b0;
            // Mode press has priority over a coincident inc press or tick.
            if (mode_press) begin
                state_q       <= next_mode(state_q);
                clr_seconds_q <= (state_q == RUN);
                blink_q       <= 1'b0;
                tcnt_q        <= '0;
            end else if (in_set) begin
                if (inc_event) begin
                    inc_hour_q   <= (state_q == SET_HOUR);
                    inc_minute_q <= (state_q == SET_MIN);
                    tcnt_q       <= '0;
                    if (tick_1hz) begin
                        blink_q <= ~blink_q;
                    end
                end else if (tick_1hz) begin
                    if (tcnt_q == TW'(TIMEOUT_S - 1)) begin
                        state_q <= RUN;
                        blink_q <= 1'b0;
                        tcnt_q  <= '0;
                    end else begin
                        tcnt_q  <= tcnt_q + TW'(1);
                        blink_q <= ~blink_q;
                    end
                end
            end
        end
    end

    assign run_tick    = tick_1hz & (state_q == RUN);
    assign inc_hour    = inc_hour_q;
    assign inc_minute  = inc_minute_q;
    assign clr_seconds = clr_seconds_q;
    assign blank_h     = (state_q == SET_HOUR) & blink_q;
    assign blank_m     = (state_q == SET_MIN) & blink_q;
    assign set_active  = in_set;

endmodule
